// File: rtl/memory_access_unit.sv
// memory_access_unit: MA stage of the SimpleRISC pipeline.
// Issues ld/st over a req/ready + rvalid handshake and fills the MA/RW latch.
module memory_access_unit #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              isLd,
    input  logic              isSt,
    input  logic              isWb,
    input  logic              isCall,
    input  logic [3:0]        rd,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] pc,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              out_valid,
    output logic              out_isWb,
    output logic              out_isLd,
    output logic              out_isCall,
    output logic [3:0]        out_rd,
    output logic [DATA_W-1:0] out_aluResult,
    output logic [DATA_W-1:0] out_ldResult,
    output logic [DATA_W-1:0] out_pc,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        wait_cnt;
    logic              lat_wb;
    logic              lat_call;
    logic [3:0]        lat_rd;
    logic [DATA_W-1:0] lat_pc;

    logic fault;
    logic acc_plain;
    logic acc_fault;
    logic acc_mem;
    logic fin_mem;
    logic timeout;

    assign stall   = (state != IDLE);
    assign mem_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        acc_plain = 1'b0;
        acc_fault = 1'b0;
        acc_mem   = 1'b0;
        fin_mem   = 1'b0;
        timeout   = 1'b0;
        fault     = (isLd & isSt) |
                    ((isLd | isSt) & (aluResult[1:0] != 2'b00));
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (fault) begin
                        acc_fault = 1'b1;
                    end else if (isLd | isSt) begin
                        acc_mem  = 1'b1;
                        state_nx = REQ;
                    end else begin
                        acc_plain = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    // a load whose data arrives with the accept skips WAIT
                    if (mem_we || mem_rvalid) begin
                        fin_mem  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    fin_mem  = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == WAIT_LIM) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            lat_wb        <= 1'b0;
            lat_call      <= 1'b0;
            lat_rd        <= '0;
            lat_pc        <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            out_valid     <= 1'b0;
            err           <= 1'b0;
            out_isWb      <= 1'b0;
            out_isLd      <= 1'b0;
            out_isCall    <= 1'b0;
            out_rd        <= '0;
            out_aluResult <= '0;
            out_ldResult  <= '0;
            out_pc        <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (state == REQ)       wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
            if (acc_mem) begin
                mem_we    <= isSt;
                mem_addr  <= aluResult;
                mem_wdata <= op2;
                lat_wb    <= isWb;
                lat_call  <= isCall;
                lat_rd    <= rd;
                lat_pc    <= pc;
            end
            if (acc_plain || acc_fault) begin
                out_valid     <= 1'b1;
                err           <= acc_fault;
                out_isWb      <= isWb & ~acc_fault;
                out_isLd      <= isLd & ~acc_fault;
                out_isCall    <= isCall;
                out_rd        <= rd;
                out_aluResult <= aluResult;
                out_ldResult  <= '0;
                out_pc        <= pc;
            end
            if (fin_mem || timeout) begin
                out_valid     <= 1'b1;
                err           <= timeout;
                out_isWb      <= lat_wb & ~timeout;
                out_isLd      <= ~mem_we;
                out_isCall    <= lat_call;
                out_rd        <= lat_rd;
                out_aluResult <= mem_addr;
                out_ldResult  <= (fin_mem && !mem_we) ? mem_rdata : '0;
                out_pc        <= lat_pc;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed stimulus with a transaction scoreboard
// for the MA stage; every MA/RW latch pulse is matched against it.
module tb_memory_access_unit;

    localparam int MAXW = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, isLd, isSt, isWb, isCall;
    logic [3:0]  rd;
    logic [31:0] aluResult, op2, pc;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_isWb, out_isLd, out_isCall;
    logic [3:0]  out_rd;
    logic [31:0] out_aluResult, out_ldResult, out_pc;
    logic        err;

    memory_access_unit #(.DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .isLd(isLd), .isSt(isSt), .isWb(isWb), .isCall(isCall),
        .rd(rd), .aluResult(aluResult), .op2(op2), .pc(pc),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .out_valid(out_valid), .out_isWb(out_isWb),
        .out_isLd(out_isLd), .out_isCall(out_isCall),
        .out_rd(out_rd), .out_aluResult(out_aluResult),
        .out_ldResult(out_ldResult), .out_pc(out_pc), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb;
        logic        ld;
        logic        call;
        logic [3:0]  rd;
        logic [31:0] alu;
        logic [31:0] ldr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // MA/RW latch checked on every falling edge: pulses pop the scoreboard,
    // idle cycles must hold the last written values with err low.
    always @(negedge clk) begin
        if (rst) begin
            last = '{default: '0};
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                last = exp_q.pop_front();
                chk("cmp_isWb",   64'(out_isWb),   64'(last.wb));
                chk("cmp_isLd",   64'(out_isLd),   64'(last.ld));
                chk("cmp_isCall", 64'(out_isCall), 64'(last.call));
                chk("cmp_rd",     64'(out_rd),     64'(last.rd));
                chk("cmp_alu",    64'(out_aluResult), 64'(last.alu));
                chk("cmp_ldres",  64'(out_ldResult),  64'(last.ldr));
                chk("cmp_pc",     64'(out_pc),     64'(last.pc));
                chk("cmp_err",    64'(err),        64'(last.err));
            end
        end else begin
            chk("idle_err", 64'(err), 64'd0);
            chk("hold_alu", 64'(out_aluResult), 64'(last.alu));
            chk("hold_ldres", 64'(out_ldResult), 64'(last.ldr));
            chk("hold_rd", 64'(out_rd), 64'(last.rd));
            chk("hold_pc", 64'(out_pc), 64'(last.pc));
        end
    end

    task automatic drive(input logic ld, input logic st, input logic wb,
                         input logic call, input logic [3:0] r,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p);
        in_valid  = 1'b1;
        isLd      = ld;
        isSt      = st;
        isWb      = wb;
        isCall    = call;
        rd        = r;
        aluResult = a;
        op2       = d;
        pc        = p;
    endtask

    task automatic idle_in;
        in_valid = 1'b0;
        isLd     = 1'b0;
        isSt     = 1'b0;
        isWb     = 1'b0;
        isCall   = 1'b0;
    endtask

    // Single-cycle op (ALU or faulting ld/st): result one edge later.
    task automatic simple_op(input logic ld, input logic st, input logic wb,
                             input logic call, input logic [3:0] r,
                             input logic [31:0] a, input logic [31:0] p);
        logic f;
        f = (ld & st) | ((ld | st) & (a[1:0] != 2'b00));
        exp_q.push_back('{wb & ~f, ld & ~f, call, r, a, 32'd0, p, f});
        drive(ld, st, wb, call, r, a, 32'h5A5A5A5A, p);
        tick();
        idle_in();
        chk("simple_valid", 64'(out_valid), 64'd1);
        chk("simple_err", 64'(err), 64'(f));
        chk("simple_nostall", 64'(stall), 64'd0);
        chk("simple_noreq", 64'(mem_req), 64'd0);
    endtask

    // Memory op: ready on request cycle rdy_lat, rvalid rv_lat cycles after
    // the accept (rv_lat < 0: never). Returns the stall cycle count.
    task automatic mem_op(input logic ld, input logic wb, input logic call,
                          input logic [3:0] r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] p,
                          input int rdy_lat, input int rv_lat,
                          input logic [31:0] rdata, output int n_stall);
        int   n_req;
        int   cyc;
        int   exp_stall;
        logic stable;
        logic to;
        to = ld && (rv_lat < 0);
        if (!ld)     exp_stall = rdy_lat + 1;
        else if (to) exp_stall = rdy_lat + 1 + MAXW + 1;
        else         exp_stall = rdy_lat + 1 + rv_lat;
        exp_q.push_back('{wb & ~to, ld, call, r, a,
                          (ld && !to) ? rdata : 32'd0, p, to});
        drive(ld, ~ld, wb, call, r, a, d, p);
        mem_ready = 1'b1;
        tick();
        idle_in();
        n_stall = 0;
        n_req   = 0;
        cyc     = 0;
        stable  = 1'b1;
        while (stall && cyc < 600) begin
            n_stall++;
            if (mem_req) begin
                n_req++;
                if (mem_addr !== a || mem_we !== ~ld ||
                    (!ld && mem_wdata !== d))
                    stable = 1'b0;
            end
            mem_ready  = (cyc == rdy_lat);
            mem_rvalid = ld && rv_lat >= 0 && (cyc == rdy_lat + rv_lat);
            mem_rdata  = mem_rvalid ? rdata : 32'hBAD0BAD0;
            tick();
            cyc++;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("mem_stall_cycles", 64'(n_stall), 64'(exp_stall));
        chk("mem_req_cycles", 64'(n_req), 64'(rdy_lat + 1));
        chk("mem_req_stable", 64'(stable), 64'd1);
        chk("mem_done_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        aluResult  = '0;
        op2        = '0;
        pc         = '0;
        rd         = '0;
        idle_in();
        repeat (3) tick();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_alu", 64'(out_aluResult), 64'd0);
        rst = 1'b0;
        tick();

        simple_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 32'hEEEEEEEE, 32'h10);
        chk("alu_rd", 64'(out_rd), 64'd4);
        chk("alu_result", 64'(out_aluResult), 64'hEEEEEEEE);
        tick();
        chk("alu_pulse_ends", 64'(out_valid), 64'd0);

        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b1, 1'b0, i == 1, 4'(i + 1),
                              32'h1000 + 32'(i), 32'd0, 32'h200 + 32'(4 * i),
                              1'b0});
            drive(1'b0, 1'b0, 1'b1, i == 1, 4'(i + 1),
                  32'h1000 + 32'(i), 32'd0, 32'h200 + 32'(4 * i));
            tick();
            chk("b2b_valid", 64'(out_valid), 64'd1);
        end
        idle_in();
        tick();

        mem_op(1'b1, 1'b1, 1'b0, 4'd7, 32'h20, 32'h0, 32'h104,
               0, 3, 32'hDDDDDDDD, n);
        chk("ld_stall_4", 64'(n), 64'd4);
        chk("ld_result", 64'(out_ldResult), 64'hDDDDDDDD);
        chk("ld_isLd", 64'(out_isLd), 64'd1);
        tick();

        mem_op(1'b0, 1'b0, 1'b0, 4'd2, 32'h40, 32'h11111111, 32'h108,
               2, 0, 32'h0, n);
        chk("st_stall_3", 64'(n), 64'd3);
        chk("st_isLd", 64'(out_isLd), 64'd0);

        mem_op(1'b1, 1'b1, 1'b1, 4'd9, 32'h84, 32'h0, 32'h10C,
               1, 0, 32'hCAFEF00D, n);
        chk("ld_same_cycle_stall", 64'(n), 64'd2);

        simple_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h22, 32'h110);
        chk("mis_isWb", 64'(out_isWb), 64'd0);
        simple_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 32'h30, 32'h114);
        simple_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 32'h41, 32'h118);
        tick();

        mem_op(1'b1, 1'b1, 1'b0, 4'd8, 32'h50, 32'h0, 32'h11C,
               0, -1, 32'h0, n);
        chk("timeout_stall", 64'(n), 64'd257);
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_ldres", 64'(out_ldResult), 64'd0);
        tick();

        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h60, 32'h0, 32'h120);
        tick();
        idle_in();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("pre_rst_in_wait", 64'(stall), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wait_rst_stall", 64'(stall), 64'd0);
        chk("wait_rst_valid", 64'(out_valid), 64'd0);
        chk("wait_rst_addr", 64'(mem_addr), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDDDDDDDD;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_valid", 64'(out_valid), 64'd0);
        chk("late_rvalid_stall", 64'(stall), 64'd0);
        repeat (2) tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
